// File: rtl/pos_snap_sched.sv
// Snapshot read scheduler: freezes x/y/status/sequence at each I2C read start and serves them bytewise.
// Optional SERVE watchdog enabled by defining SNAP_TIMEOUT_EN.
module pos_snap_sched #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x_pos,
    input  logic [7:0] y_pos,
    input  logic [7:0] status,
    input  logic       move_req,
    output logic       move_gnt,
    input  logic       tx_start,
    input  logic       byte_req,
    input  logic       tx_stop,
    input  logic       ptr_load,
    input  logic [1:0] ptr_val,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic [1:0] ptr,
    output logic       overrun,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] shadow_x_r;
    logic [7:0] shadow_y_r;
    logic [7:0] shadow_st_r;
    logic [7:0] shadow_seq_r;
    logic [7:0] seq_r;
    logic [7:0] shadow_sel_s;
    logic [7:0] rd_data_r;
    logic       rd_valid_r;
    logic [1:0] ptr_r;
    logic       overrun_r;
    logic       timeout_r;
    logic       timeout_hit_s;

`ifdef SNAP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wdog_cnt_r;

    // Watchdog counts idle SERVE cycles; held at zero outside SERVE and on each byte request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_r <= {CW{1'b0}};
        end else if ((state_r != ST_SERVE) || byte_req) begin
            wdog_cnt_r <= {CW{1'b0}};
        end else begin
            wdog_cnt_r <= wdog_cnt_r + CW'(1);
        end
    end

    assign timeout_hit_s = (state_r == ST_SERVE) && (wdog_cnt_r == CW'(TIMEOUT_CYC - 1)) &&
                           !byte_req && !tx_stop && !tx_start;
`else
    assign timeout_hit_s = 1'b0;
`endif

    assign move_gnt = move_req & (state_r != ST_SNAP);
    assign busy     = (state_r != ST_IDLE);
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign ptr      = ptr_r;
    assign overrun  = overrun_r;
    assign timeout  = timeout_r;

    // Select the shadow byte addressed by the register pointer
    always_comb begin
        shadow_sel_s = 8'h00;
        case (ptr_r)
            2'd0:    shadow_sel_s = shadow_x_r;
            2'd1:    shadow_sel_s = shadow_y_r;
            2'd2:    shadow_sel_s = shadow_st_r;
            2'd3:    shadow_sel_s = shadow_seq_r;
            default: shadow_sel_s = 8'h00;
        endcase
    end

    // Next-state logic; in SERVE a stop beats a repeated start
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tx_start) begin
                    state_next_s = ST_SNAP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SNAP: state_next_s = ST_SERVE;
            ST_SERVE: begin
                if (tx_stop) begin
                    state_next_s = ST_IDLE;
                end else if (tx_start) begin
                    state_next_s = ST_SNAP;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SERVE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Snapshot capture, byte serving, pointer and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_x_r   <= 8'h00;
            shadow_y_r   <= 8'h00;
            shadow_st_r  <= 8'h00;
            shadow_seq_r <= 8'h00;
            seq_r        <= 8'h00;
            rd_data_r    <= 8'h00;
            rd_valid_r   <= 1'b0;
            ptr_r        <= 2'd0;
            overrun_r    <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            if (tx_start) begin
                overrun_r <= 1'b0;
                timeout_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (ptr_load) begin
                        ptr_r <= ptr_val;
                    end
                    if (byte_req) begin
                        overrun_r <= 1'b1;
                    end
                end
                ST_SNAP: begin
                    shadow_x_r   <= x_pos;
                    shadow_y_r   <= y_pos;
                    shadow_st_r  <= status;
                    seq_r        <= seq_r + 8'd1;
                    shadow_seq_r <= seq_r + 8'd1;
                    if (byte_req) begin
                        overrun_r <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (timeout_hit_s) begin
                        timeout_r <= 1'b1;
                    end else if (byte_req && !tx_stop && !tx_start) begin
                        rd_data_r  <= shadow_sel_s;
                        rd_valid_r <= 1'b1;
                        ptr_r      <= ptr_r + 2'd1;
                    end
                end
                default: rd_valid_r <= 1'b0;
            endcase
        end
    end

endmodule
